// File: rtl/packet_merge.sv
// Two-input round-robin packet arbiter feeding the packet queue; one packet in flight.
// Define PACKET_MERGE_FIXED_PRIO_EN to make port A always win ties.
module packet_merge #(
  parameter int PACKET_WIDTH = 175
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RECEIVE_A_VALID,
  input  logic [PACKET_WIDTH-1:0] RECEIVE_A_DATA,
  output logic                    RECEIVE_A_READY,
  input  logic                    RECEIVE_B_VALID,
  input  logic [PACKET_WIDTH-1:0] RECEIVE_B_DATA,
  output logic                    RECEIVE_B_READY,
  output logic                    SEND_PC_VALID,
  output logic [PACKET_WIDTH-1:0] SEND_PC_DATA,
  input  logic                    SEND_PC_READY
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCEPT = 2'd1, S_SEND = 2'd2} state_e;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    a_ready_q, a_ready_d;
  logic                    b_ready_q, b_ready_d;
  logic                    send_valid_q, send_valid_d;
  logic [PACKET_WIDTH-1:0] send_data_q, send_data_d;
  logic                    tie_pick;
  logic                    granted_valid;
  logic                    capture;

`ifdef PACKET_MERGE_FIXED_PRIO_EN
  assign tie_pick = PORT_A;
`else
  assign tie_pick = ~last_grant_q;
`endif

  assign granted_valid = (grant_q == PORT_B) ? RECEIVE_B_VALID : RECEIVE_A_VALID;
  // A sender that dropped VALID during its READY cycle is treated as withdrawn.
  assign capture       = (state_q == S_ACCEPT) && granted_valid;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      grant_q      <= PORT_A;
      last_grant_q <= PORT_B;
      a_ready_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      a_ready_q    <= a_ready_d;
      b_ready_q    <= b_ready_d;
      send_valid_q <= send_valid_d;
      send_data_q  <= send_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (RECEIVE_A_VALID || RECEIVE_B_VALID) begin
          state_d = S_ACCEPT;
          grant_d = (RECEIVE_A_VALID && RECEIVE_B_VALID) ? tie_pick : RECEIVE_B_VALID;
        end
      end
      S_ACCEPT: state_d = granted_valid ? S_SEND : S_IDLE;
      S_SEND:   if (SEND_PC_READY) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_ready_d    = (state_q == S_IDLE) && (state_d == S_ACCEPT) && (grant_d == PORT_A);
    b_ready_d    = (state_q == S_IDLE) && (state_d == S_ACCEPT) && (grant_d == PORT_B);
    send_valid_d = (state_d == S_SEND);
    send_data_d  = send_data_q;
    last_grant_d = last_grant_q;
    if (capture) begin
      send_data_d  = (grant_q == PORT_B) ? RECEIVE_B_DATA : RECEIVE_A_DATA;
      last_grant_d = grant_q;
    end
  end

  assign RECEIVE_A_READY = a_ready_q;
  assign RECEIVE_B_READY = b_ready_q;
  assign SEND_PC_VALID   = send_valid_q;
  assign SEND_PC_DATA    = send_data_q;

endmodule
